trig_overlay_multi: RTL and testbench
=====================================

// Module: trig_overlay_multi
// PURPOSE
//   Multi-channel trigger overlay generator for the scope's VGA pixel pipeline. Per enabled channel, draws a
//   horizontal trigger-level line across the waveform area plus a left-edge arrow marker, with per-channel
//   armed/fired status animation (blink while armed, solid hold after a trigger). Levels are frame-latched
//   to prevent tearing. Output: 2-cycle-registered display bit + winning channel index for the colour mux.
// PARAMETERS
//   NUM_CH       2    number of trigger channels (1..8)
//   COORD_W      10   width of pixel coordinates and trigger levels
//   AREA_X0      0    waveform area left column (inclusive)
//   AREA_X1      639  waveform area right column (inclusive)
//   AREA_Y0      0    waveform area top row (inclusive)
//   AREA_Y1      479  waveform area bottom row (inclusive)
//   DASH_LOG2    2    dash period = 2^(DASH_LOG2+1) px; on for x[DASH_LOG2]==0
//   MARKER_W     8    arrow marker width in px (>=2, < AREA_X1-AREA_X0)
//   BLINK_FRAMES 16   armed blink period in frames (even, >=2)
//   HOLD_FRAMES  30   frames a fired channel stays solid after last trig_fired (>=1)
// PORTS
//   clk          in   1                  pixel clock
//   rst_n        in   1                  asynchronous active-low reset
//   frame_start  in   1                  1-cycle pulse at start of vertical blank
//   pix_valid    in   1                  x_in/y_in are an active pixel this cycle
//   x_in         in   COORD_W            current pixel column
//   y_in         in   COORD_W            current pixel row
//   trig_level   in   NUM_CH*COORD_W     per-channel level as screen row; ch i at [i*COORD_W +: COORD_W]
//   ch_enable    in   NUM_CH             channel overlay enable
//   trig_armed   in   NUM_CH             channel trigger armed (level)
//   trig_fired   in   NUM_CH             1-cycle pulse per trigger event
//   sel_ch       in   $clog2(NUM_CH)+1   selected channel: line drawn solid; value >= NUM_CH = none
//   display      out  1                  overlay pixel on (qualified by pix_valid_out)
//   display_ch   out  $clog2(NUM_CH)+1   channel owning the pixel; 0 when display==0
//   pix_valid_out out 1                  pix_valid delayed 2 cycles
// BEHAVIOUR
// - Reset: display=0, display_ch=0, pix_valid_out=0; all channel states IDLE; shadow levels, hold counters,
//   frame counter = 0.
// - Shadow level: on frame_start, lvl_q[i] <= trig_level[i] for all i; drawing uses lvl_q only.
// - Frame counter fc: increments mod BLINK_FRAMES on each frame_start. blink_on = (fc < BLINK_FRAMES/2).
// - Per-channel FSM (state in registers, evaluated every clk):
//   IDLE : ch_enable=1 & trig_armed=1 -> ARMED; ch_enable=1 & trig_fired -> FIRED (hold=HOLD_FRAMES).
//   ARMED: trig_fired -> FIRED, hold<=HOLD_FRAMES; trig_armed=0 -> IDLE.
//   FIRED: trig_fired -> reload hold=HOLD_FRAMES; else on frame_start hold--; at hold==1 with frame_start
//          -> ARMED if trig_armed else IDLE.
//   Any state: ch_enable=0 -> IDLE (overrides everything, same cycle).
//   trig_fired coincident with frame_start: fired wins, hold loaded, no decrement that cycle.
// - Visibility: IDLE-enabled and FIRED: line+marker; ARMED: marker always, line only when blink_on;
//   disabled channel: nothing.
// - Stage 1 (registered): per channel
//   line_hit   = y_in==lvl_q & AREA_X0<=x_in<=AREA_X1 & (i==sel_ch | x_in[DASH_LOG2]==0) & line visible
//   marker_hit = d=x_in-AREA_X0 < MARKER_W & |y_in - mrow| <= (MARKER_W-1-d)>>1, mrow=lvl_q clamped to
//                [AREA_Y0,AREA_Y1]; lvl_q out of area suppresses line_hit only. Use COORD_W+1 signed math.
//   pix_valid, hit vector registered together.
// - Stage 2 (registered): display = pix_valid_d1 & |hit; display_ch = lowest index i with hit[i], else 0.
// - Latency exactly 2 clk from x_in/y_in/pix_valid to outputs; no stalls, one pixel per clk.
// - pix_valid=0: that pixel's display forced 0; FSM/counters unaffected by pix_valid.
// - State changes take effect on pixels entering stage 1 the cycle after the change.
// - Async reset mid-frame: outputs drop to 0 immediately; drawing resumes after next frame_start latches levels.
// TESTING
// 1 Reset/latch: rst_n low, then trig_level[0]=100, ch_enable=1, no frame_start -> lvl_q=0, row 100 dark;
//   after frame_start -> pixel (320,100) gives display=1, display_ch=0, 2 cycles later.
// 2 Dash/select: ch0 lvl 100, sel_ch=NUM_CH -> x=4..7 dark, x=0..3,8..11 lit (beyond marker); sel_ch=0 ->
//   all x in area lit on row 100.
// 3 Blink: ch0 ARMED, 16 frame_starts -> line visible frames fc 0..7, hidden 8..15; marker lit all frames.
// 4 Hold: trig_fired on ch0 -> solid; fire again after 10 frames -> solid 30 more frames, then ARMED;
//   trig_fired same cycle as frame_start -> hold=30, no decrement.
// 5 Priority/clamp: ch0,ch1 both lvl 200 -> display_ch=0; ch1 lvl 600 -> no line, marker at row 479.
// 6 Disable/reset: ch_enable=0 while FIRED -> IDLE next clk, no pixels; rst_n pulse mid-line -> outputs 0 async.

Source files
------------

// File: rtl/trig_overlay_multi.sv
// -----------------------------------------------------------------------------
// trig_overlay_multi
//   Multi-channel trigger overlay for the scope's VGA pixel pipeline. For each
//   enabled channel it draws a horizontal trigger-level line across the
//   waveform area and a left-edge arrow marker. It also animates the channel
//   status: the line blinks while the channel is armed, and it is held solid
//   for a number of frames after a trigger event. Levels are latched at
//   frame_start so that a level change never tears a frame.
//
// Ports
//   clk, rst_n     pixel clock, asynchronous active-low reset
//   frame_start    1-cycle pulse at the start of vertical blank
//   pix_valid      x_in/y_in carry an active pixel this cycle
//   x_in, y_in     current pixel column / row
//   trig_level     per-channel level (screen row), ch i at [i*COORD_W +: COORD_W]
//   ch_enable      per-channel overlay enable
//   trig_armed     per-channel armed level
//   trig_fired     per-channel 1-cycle trigger event pulse
//   sel_ch         selected channel: its line is solid; >= NUM_CH selects none
//   display        overlay pixel on (qualified by pix_valid_out)
//   display_ch     lowest channel owning the pixel, 0 when display is 0
//   pix_valid_out  pix_valid delayed by the two pipeline stages
// -----------------------------------------------------------------------------
module trig_overlay_multi #(
  parameter int NUM_CH       = 2,
  parameter int COORD_W      = 10,
  parameter int AREA_X0      = 0,
  parameter int AREA_X1      = 639,
  parameter int AREA_Y0      = 0,
  parameter int AREA_Y1      = 479,
  parameter int DASH_LOG2    = 2,
  parameter int MARKER_W     = 8,
  parameter int BLINK_FRAMES = 16,
  parameter int HOLD_FRAMES  = 30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [COORD_W-1:0]          x_in,
  input  logic [COORD_W-1:0]          y_in,
  input  logic [NUM_CH*COORD_W-1:0]   trig_level,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH-1:0]           trig_armed,
  input  logic [NUM_CH-1:0]           trig_fired,
  input  logic [$clog2(NUM_CH):0]     sel_ch,
  output logic                        display,
  output logic [$clog2(NUM_CH):0]     display_ch,
  output logic                        pix_valid_out
);

  localparam int SEL_W  = $clog2(NUM_CH) + 1;
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  // One extra bit so that coordinate differences can be handled as signed values
  localparam int SW     = COORD_W + 1;

  localparam logic signed [SW-1:0] X0_S     = SW'(AREA_X0);
  localparam logic signed [SW-1:0] X1_S     = SW'(AREA_X1);
  localparam logic signed [SW-1:0] Y0_S     = SW'(AREA_Y0);
  localparam logic signed [SW-1:0] Y1_S     = SW'(AREA_Y1);
  localparam logic signed [SW-1:0] MW_S     = SW'(MARKER_W);
  localparam logic signed [SW-1:0] MW_M1_S  = SW'(MARKER_W - 1);
  localparam logic signed [SW-1:0] ZERO_S   = SW'(0);
  localparam logic [FC_W-1:0]      FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0]      FC_HALF  = FC_W'(BLINK_FRAMES / 2);
  localparam logic [HOLD_W-1:0]    HOLD_LD  = HOLD_W'(HOLD_FRAMES);
  localparam logic [HOLD_W-1:0]    HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } ch_state_e;

  logic [COORD_W-1:0] lvl_r [NUM_CH];
  logic [NUM_CH-1:0]  en_r;
  logic [FC_W-1:0]    fc_r;
  logic [FC_W-1:0]    fc_nxt_s;
  logic               blink_on_s;

  ch_state_e          state_r     [NUM_CH];
  ch_state_e          state_nxt_s [NUM_CH];
  logic [HOLD_W-1:0]  hold_r      [NUM_CH];
  logic [HOLD_W-1:0]  hold_nxt_s  [NUM_CH];

  logic signed [SW-1:0] x_s;
  logic signed [SW-1:0] y_s;
  logic                 x_in_area_s;
  logic [NUM_CH-1:0]    hit_s;

  logic                 pv_d1_r;
  logic [NUM_CH-1:0]    hit_r;
  logic [SEL_W-1:0]     first_ch_s;
  logic                 any_hit_s;
  logic                 display_r;
  logic [SEL_W-1:0]     display_ch_r;
  logic                 pv_d2_r;

  assign fc_nxt_s   = (fc_r == FC_LAST) ? '0 : fc_r + FC_W'(1);
  assign blink_on_s = (fc_r < FC_HALF);

  // Frame-latched levels, registered enables and the blink frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lvl_r[i] <= '0;
      end
      en_r <= '0;
      fc_r <= '0;
    end else begin
      en_r <= ch_enable;
      if (frame_start) begin
        for (int i = 0; i < NUM_CH; i++) begin
          lvl_r[i] <= trig_level[i*COORD_W +: COORD_W];
        end
        fc_r <= fc_nxt_s;
      end else begin
        fc_r <= fc_r;
      end
    end
  end

  // Per-channel status next-state: disable overrides everything, a trigger
  // event beats the frame decrement in the same cycle
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt_s[i] = state_r[i];
      hold_nxt_s[i]  = hold_r[i];
      if (!ch_enable[i]) begin
        state_nxt_s[i] = ST_IDLE;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (trig_fired[i]) begin
              state_nxt_s[i] = ST_FIRED;
              hold_nxt_s[i]  = HOLD_LD;
            end else if (trig_armed[i]) begin
              state_nxt_s[i] = ST_ARMED;
            end else begin
              state_nxt_s[i] = ST_IDLE;
            end
          end
          ST_ARMED: begin
            if (trig_fired[i]) begin
              state_nxt_s[i] = ST_FIRED;
              hold_nxt_s[i]  = HOLD_LD;
            end else if (!trig_armed[i]) begin
              state_nxt_s[i] = ST_IDLE;
            end else begin
              state_nxt_s[i] = ST_ARMED;
            end
          end
          ST_FIRED: begin
            if (trig_fired[i]) begin
              hold_nxt_s[i] = HOLD_LD;
            end else if (frame_start) begin
              if (hold_r[i] == HOLD_ONE) begin
                state_nxt_s[i] = trig_armed[i] ? ST_ARMED : ST_IDLE;
              end else begin
                hold_nxt_s[i] = hold_r[i] - HOLD_ONE;
              end
            end else begin
              hold_nxt_s[i] = hold_r[i];
            end
          end
          default: begin
            state_nxt_s[i] = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Per-channel status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= ST_IDLE;
        hold_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= state_nxt_s[i];
        hold_r[i]  <= hold_nxt_s[i];
      end
    end
  end

  assign x_s         = $signed({1'b0, x_in});
  assign y_s         = $signed({1'b0, y_in});
  assign x_in_area_s = (x_s >= X0_S) && (x_s <= X1_S);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic signed [SW-1:0] lvl_s;
    logic signed [SW-1:0] mrow_s;
    logic signed [SW-1:0] dx_s;
    logic signed [SW-1:0] dy_s;
    logic signed [SW-1:0] ady_s;
    logic signed [SW-1:0] lim_s;
    logic                 lvl_in_area_s;
    logic                 dash_on_s;
    logic                 line_vis_s;
    logic                 line_hit_s;
    logic                 marker_hit_s;

    assign lvl_s         = $signed({1'b0, lvl_r[g]});
    assign lvl_in_area_s = (lvl_s >= Y0_S) && (lvl_s <= Y1_S);
    // The selected channel is drawn solid, all others dashed
    assign dash_on_s     = (sel_ch == SEL_W'(g)) || !x_in[DASH_LOG2];
    assign line_vis_s    = en_r[g] && ((state_r[g] != ST_ARMED) || blink_on_s);
    assign line_hit_s    = (y_in == lvl_r[g]) && x_in_area_s && lvl_in_area_s &&
                           dash_on_s && line_vis_s;

    // The marker stays on screen even when the level is off-area: pin its row to the area edge
    assign mrow_s        = (lvl_s < Y0_S) ? Y0_S : ((lvl_s > Y1_S) ? Y1_S : lvl_s);
    assign dx_s          = x_s - X0_S;
    assign dy_s          = y_s - mrow_s;
    assign ady_s         = dy_s[SW-1] ? -dy_s : dy_s;
    // Arrow narrows to the right: half-height shrinks by one every two columns
    assign lim_s         = (MW_M1_S - dx_s) >>> 1;
    assign marker_hit_s  = en_r[g] && (dx_s >= ZERO_S) && (dx_s < MW_S) && (ady_s <= lim_s);

    assign hit_s[g]      = line_hit_s || marker_hit_s;
  end

  // Stage 1: per-channel hits registered together with the pixel qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_d1_r <= 1'b0;
      hit_r   <= '0;
    end else begin
      pv_d1_r <= pix_valid;
      hit_r   <= hit_s;
    end
  end

  // Lowest-index hit owns the pixel
  always_comb begin
    first_ch_s = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      first_ch_s = hit_r[i] ? SEL_W'(i) : first_ch_s;
    end
  end

  assign any_hit_s = pv_d1_r && (|hit_r);

  // Stage 2: registered display bit, owner index and delayed qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_r    <= 1'b0;
      display_ch_r <= '0;
      pv_d2_r      <= 1'b0;
    end else begin
      display_r    <= any_hit_s;
      display_ch_r <= any_hit_s ? first_ch_s : '0;
      pv_d2_r      <= pv_d1_r;
    end
  end

  assign display       = display_r;
  assign display_ch    = display_ch_r;
  assign pix_valid_out = pv_d2_r;

endmodule

// File: tb/tb_trig_overlay_multi.sv
// -----------------------------------------------------------------------------
// tb_trig_overlay_multi
//   Self-checking bench for trig_overlay_multi (default parameters). A
//   behavioural model tracks the latched levels, the frame count and, per
//   channel, the remaining solid-hold frames and the armed flag. It predicts
//   every output pixel two clocks after it is presented. Directed scenarios
//   are followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_trig_overlay_multi;

  localparam int NCH   = 2;
  localparam int CW    = 10;
  localparam int X0    = 0;
  localparam int X1    = 639;
  localparam int Y0    = 0;
  localparam int Y1    = 479;
  localparam int DASHP = 4;
  localparam int MW    = 8;
  localparam int BLINK = 16;
  localparam int HOLD  = 30;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_start;
  logic            pix_valid;
  logic [CW-1:0]   x_in;
  logic [CW-1:0]   y_in;
  logic [NCH*CW-1:0] trig_level;
  logic [NCH-1:0]  ch_enable;
  logic [NCH-1:0]  trig_armed;
  logic [NCH-1:0]  trig_fired;
  logic [1:0]      sel_ch;
  logic            display;
  logic [1:0]      display_ch;
  logic            pix_valid_out;

  trig_overlay_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .trig_level   (trig_level),
    .ch_enable    (ch_enable),
    .trig_armed   (trig_armed),
    .trig_fired   (trig_fired),
    .sel_ch       (sel_ch),
    .display      (display),
    .display_ch   (display_ch),
    .pix_valid_out(pix_valid_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int nframes  = 0;

  // Model state
  int m_lvl  [NCH];
  int m_hold [NCH];   // >0: solid after a trigger, counts remaining frames
  bit m_arm  [NCH];
  bit m_en   [NCH];
  int m_fc;
  // Prediction for the pixel currently in the first pipeline stage
  bit e1_v, e1_d;
  int e1_ch;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NCH; i++) begin
      m_lvl[i] = 0; m_hold[i] = 0; m_arm[i] = 0; m_en[i] = 0;
    end
    m_fc = 0; e1_v = 0; e1_d = 0; e1_ch = 0; nframes = 0;
  endtask

  function automatic bit ch_hit(int i, int x, int y, int sel);
    bit armed_only, line_on, on_line, on_marker;
    int mrow, dx, ady;
    if (!m_en[i]) return 1'b0;
    armed_only = (m_hold[i] == 0) && m_arm[i];
    line_on    = !armed_only || (m_fc < BLINK / 2);
    on_line    = line_on && (y == m_lvl[i]) && (m_lvl[i] >= Y0) && (m_lvl[i] <= Y1) &&
                 (x >= X0) && (x <= X1) && ((sel == i) || ((x / DASHP) % 2 == 0));
    mrow       = (m_lvl[i] < Y0) ? Y0 : ((m_lvl[i] > Y1) ? Y1 : m_lvl[i]);
    dx         = x - X0;
    ady        = (y > mrow) ? (y - mrow) : (mrow - y);
    on_marker  = (dx >= 0) && (dx < MW) && (2 * ady <= MW - 1 - dx);
    return on_line || on_marker;
  endfunction

  task automatic model_update();
    for (int i = 0; i < NCH; i++) begin
      if (!ch_enable[i]) begin
        m_hold[i] = 0; m_arm[i] = 0;
      end else if (trig_fired[i]) begin
        m_hold[i] = HOLD;
      end else if (m_hold[i] > 0) begin
        if (frame_start) begin
          m_hold[i] = m_hold[i] - 1;
          if (m_hold[i] == 0) m_arm[i] = trig_armed[i];
        end
      end else begin
        m_arm[i] = trig_armed[i];
      end
      m_en[i] = ch_enable[i];
      if (frame_start) m_lvl[i] = int'(trig_level[i*CW +: CW]);
    end
    if (frame_start) m_fc = (m_fc + 1) % BLINK;
  endtask

  // One clock: predict the presented pixel, advance model, check the output pixel
  task automatic step();
    bit nv, nd;
    int nch;
    nv = pix_valid; nd = 0; nch = 0;
    if (pix_valid) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (ch_hit(i, int'(x_in), int'(y_in), int'(sel_ch))) begin
          nd = 1; nch = i;
        end
      end
    end
    model_update();
    @(posedge clk); #1;
    check_val("disp", int'(display), int'(e1_d));
    check_val("disp_ch", int'(display_ch), e1_ch);
    check_val("pv_out", int'(pix_valid_out), int'(e1_v));
    e1_v = nv; e1_d = nd; e1_ch = nch;
    frame_start = 1'b0;
    trig_fired  = '0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    nframes++;
    step();
  endtask

  // Present one pixel and check it against a fixed expectation two clocks later
  task automatic probe(input string tag, input int x, input int y, input int ed, input int ech);
    pix_valid = 1'b1; x_in = CW'(x); y_in = CW'(y);
    step();
    pix_valid = 1'b0;
    step();
    check_val(tag, int'(display), ed);
    check_val({tag, "_ch"}, int'(display_ch), ech);
  endtask

  initial begin
    int lv0, lv1, j, yy, xx;
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; x_in = '0; y_in = '0;
    trig_level = '0; ch_enable = '0; trig_armed = '0; trig_fired = '0; sel_ch = 2'd2;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_disp", int'(display), 0);
    check_val("rst_ch", int'(display_ch), 0);
    check_val("rst_pvo", int'(pix_valid_out), 0);
    rst_n = 1'b1;

    // Levels only take effect after frame_start
    trig_level = {10'd0, 10'd100};
    ch_enable  = 2'b01;
    probe("t1_nolatch", 320, 100, 0, 0);
    frame();
    probe("t1_latch", 320, 100, 1, 0);

    // Dashing beyond the marker, solid when selected
    for (int x = 16; x < 28; x++) probe("t2_dash", x, 100, ((x / 4) % 2 == 0) ? 1 : 0, 0);
    sel_ch = 2'd0;
    for (int x = 20; x < 24; x++) probe("t2_sel", x, 100, 1, 0);
    sel_ch = 2'd2;

    // Armed: line blinks with the frame counter, marker always lit
    trig_armed = 2'b01;
    step();
    for (int f = 0; f < 16; f++) begin
      frame();
      probe("t3_line", 320, 100, ((nframes % BLINK) < BLINK / 2) ? 1 : 0, 0);
      probe("t3_mark", 2, 100, 1, 0);
    end

    // Fired: solid, re-fire reloads hold (also coincident with frame_start)
    trig_fired = 2'b01;
    step();
    for (int f = 0; f < 10; f++) begin
      frame();
      probe("t4_solid", 320, 100, 1, 0);
    end
    trig_fired = 2'b01;
    frame();
    for (int f = 0; f < HOLD - 1; f++) begin
      frame();
      probe("t4_hold", 320, 100, 1, 0);
    end
    frame();
    probe("t4_rearm", 320, 100, ((nframes % BLINK) < BLINK / 2) ? 1 : 0, 0);
    probe("t4_rearm_mk", 1, 100, 1, 0);

    // Priority and clamped marker
    trig_armed = 2'b00;
    ch_enable  = 2'b11;
    trig_level = {10'd200, 10'd200};
    frame();
    probe("t5_prio", 320, 200, 1, 0);
    trig_level = {10'd600, 10'd100};
    frame();
    probe("t5_noline", 320, 479, 0, 0);
    probe("t5_clamp", 3, 479, 1, 1);
    probe("t5_clamp_tip", 0, 476, 1, 1);
    probe("t5_clamp_out", 0, 475, 0, 0);

    // Disable while fired, then asynchronous reset mid-line
    trig_fired = 2'b01;
    step();
    probe("t6_fired", 320, 100, 1, 0);
    ch_enable = 2'b10;
    step();
    probe("t6_dis", 320, 100, 0, 0);
    ch_enable = 2'b11;
    step();
    pix_valid = 1'b1; x_in = 10'd320; y_in = 10'd100;
    step();
    step();
    check_val("t6_prerst", int'(display), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_disp", int'(display), 0);
    check_val("t6_rst_ch", int'(display_ch), 0);
    check_val("t6_rst_pvo", int'(pix_valid_out), 0);
    reset_model();
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    probe("t6_postrst", 320, 100, 0, 0);
    frame();
    probe("t6_resume", 320, 100, 1, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      frame_start = ($urandom_range(0, 24) == 0);
      pix_valid   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) ch_enable = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) trig_armed = 2'($urandom_range(0, 3));
      trig_fired[0] = ($urandom_range(0, 59) == 0);
      trig_fired[1] = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) begin
        lv0 = $urandom_range(0, 520);
        lv1 = $urandom_range(0, 520);
        trig_level = {10'(lv1), 10'(lv0)};
      end
      if ($urandom_range(0, 99) == 0) sel_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       xx = $urandom_range(0, 15);
        1:       xx = $urandom_range(630, 650);
        default: xx = $urandom_range(0, 700);
      endcase
      j = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 4) == 0) yy = $urandom_range(470, 490);
      else yy = m_lvl[j] + $urandom_range(0, 8) - 4;
      if (yy < 0) yy = 0;
      x_in = CW'(xx);
      y_in = CW'(yy);
      if (frame_start) nframes++;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
